// File: rtl/genetico_cfg_loader.sv
// Serial chromosome frame loader: shifts a frame into a shadow register and commits it atomically to the array buses.
// Optional even-parity trailer bit is enabled by defining GENETICO_CFG_PARITY_EN.
module genetico_cfg_loader #(
  parameter int N_LE  = 27,
  parameter int LE_W  = 15,
  parameter int N_OUT = 8,
  parameter int OUT_W = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_start,
  input  logic                   cfg_valid,
  input  logic                   cfg_bit,
  output logic                   cfg_ready,
  output logic [N_LE*LE_W-1:0]   conf_les,
  output logic [N_OUT*OUT_W-1:0] conf_outs,
  output logic                   cfg_done,
  output logic                   cfg_busy,
  output logic                   cfg_err,
  output logic                   cfg_loaded
);

  localparam int LES_W   = N_LE * LE_W;
  localparam int OUTS_W  = N_OUT * OUT_W;
  localparam int FRAME_W = LES_W + OUTS_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, PAR, COMMIT} state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [FRAME_W-1:0]   shadow_q;
  logic [LES_W-1:0]     les_q;
  logic [OUTS_W-1:0]    outs_q;
  logic                 done_q;
  logic                 busy_q;
  logic                 err_q;
  logic                 loaded_q;

  logic [FRAME_W-1:0]   shadow_d;
  logic [CNT_W-1:0]     cnt_d;

  assign shadow_d = {shadow_q[FRAME_W-2:0], cfg_bit};
  assign cnt_d    = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      les_q    <= '0;
      outs_q   <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg_start) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SHIFT: begin
          if (cfg_start) begin
            cnt_q <= '0;
          end else if (cfg_valid) begin
            shadow_q <= shadow_d;
            if (cnt_q == LAST_IDX) begin
              cnt_q <= '0;
`ifdef GENETICO_CFG_PARITY_EN
              state_q <= PAR;
`else
              // Commit straight from the incoming shift so buses and cfg_done move together.
              state_q  <= COMMIT;
              busy_q   <= 1'b0;
              {outs_q, les_q} <= shadow_d;
              done_q   <= 1'b1;
              loaded_q <= 1'b1;
`endif
            end else begin
              cnt_q <= cnt_d;
            end
          end
        end
`ifdef GENETICO_CFG_PARITY_EN
        PAR: begin
          if (cfg_start) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
          end else if (cfg_valid) begin
            busy_q <= 1'b0;
            if (~^{shadow_q, cfg_bit}) begin
              state_q  <= COMMIT;
              {outs_q, les_q} <= shadow_q;
              done_q   <= 1'b1;
              loaded_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              err_q   <= 1'b1;
            end
          end
        end
`endif
        COMMIT:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cfg_ready  = rst_n & (state_q != COMMIT);
  assign conf_les   = les_q;
  assign conf_outs  = outs_q;
  assign cfg_done   = done_q;
  assign cfg_busy   = busy_q;
  assign cfg_err    = err_q;
  assign cfg_loaded = loaded_q;

endmodule

// File: tb/tb_genetico_cfg_loader.sv
// Directed bench for genetico_cfg_loader; frames of 453 bits sent MSB first.
module tb_genetico_cfg_loader;
  localparam int FW    = 453;
  localparam int LES_W = 405;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_start, cfg_valid, cfg_bit;
  logic          cfg_ready, cfg_done, cfg_busy, cfg_err, cfg_loaded;
  logic [404:0]  conf_les;
  logic [47:0]   conf_outs;

  int checks = 0, errors = 0, done_cnt = 0, err_cnt = 0;
  int d0, e0;
  logic [FW-1:0] fa, fb, fc, fd;

  genetico_cfg_loader dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_bit(cfg_bit), .cfg_ready(cfg_ready), .conf_les(conf_les),
    .conf_outs(conf_outs), .cfg_done(cfg_done), .cfg_busy(cfg_busy),
    .cfg_err(cfg_err), .cfg_loaded(cfg_loaded)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (cfg_done) done_cnt++;
    if (cfg_err) err_cnt++;
  endtask

  task automatic start_frame();
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b1;
    tick();
    cfg_start = 1'b0; cfg_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [FW-1:0] f, input int nbits, input bit rnd);
    for (int i = 0; i < nbits; i++) begin
      if (rnd) begin
        cfg_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      cfg_valid = 1'b1;
      cfg_bit   = f[FW-1-i];
      tick();
    end
    cfg_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [FW-1:0] f, input bit rnd, input bit bad_par);
    send_bits(f, FW, rnd);
`ifdef GENETICO_CFG_PARITY_EN
    cfg_valid = 1'b1;
    cfg_bit   = (^f) ^ bad_par;
    tick();
    cfg_valid = 1'b0;
`else
    if (bad_par) $display("note: parity trailer not present in this build");
`endif
  endtask

  initial begin
    fa = '0;
    fa[14:0]          = 15'h7ABC;
    fa[LES_W+5:LES_W] = 6'd8;
    fb = {151{3'b101}};
    fc = {151{3'b011}};
    fc[FW-1:FW-6] = 6'd63;
    fd = {151{3'b110}};

    rst_n = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
    #12;
    // Reset state
    check("rst_ready", cfg_ready, 0);
    check("rst_les", conf_les, 0);
    check("rst_outs", conf_outs, 0);
    check("rst_loaded", cfg_loaded, 0);
    check("rst_busy", cfg_busy, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("ready_after_rst", cfg_ready, 1);
    check("idle_done", cfg_done, 0);

    // Basic frame A
    d0 = done_cnt;
    start_frame();
    check("busy_shift", cfg_busy, 1);
    check("no_early_load", conf_les, 0);
    send_frame(fa, 1'b0, 1'b0);
    check("a_done_latency", cfg_done, 1);
    check("a_commit_notready", cfg_ready, 0);
    check("a_outs0", conf_outs[5:0], 6'd8);
    check("a_le0", conf_les[14:0], 15'h7ABC);
    check("a_les", conf_les, fa[LES_W-1:0]);
    check("a_loaded", cfg_loaded, 1);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("a_done_pulse", cfg_done, 0);
    check("start_in_commit_ignored", cfg_busy, 0);
    check("a_done_count", done_cnt - d0, 1);

    // Same frame with gaps in cfg_valid
    d0 = done_cnt;
    start_frame();
    send_frame(fa, 1'b1, 1'b0);
    check("gap_done_latency", cfg_done, 1);
    tick();
    check("gap_les", conf_les, fa[LES_W-1:0]);
    check("gap_outs", conf_outs, fa[FW-1:LES_W]);
    check("gap_done_count", done_cnt - d0, 1);

    // cfg_valid ignored in IDLE
    send_bits(fb, 10, 1'b0);
    check("idle_valid_busy", cfg_busy, 0);
    check("idle_valid_les", conf_les, fa[LES_W-1:0]);

    // Restart: B aborted at bit 200, then C
    d0 = done_cnt;
    start_frame();
    send_bits(fb, 200, 1'b0);
    check("b_hold_les", conf_les, fa[LES_W-1:0]);
    check("b_hold_outs", conf_outs, fa[FW-1:LES_W]);
    start_frame();
    check("restart_busy", cfg_busy, 1);
    check("restart_hold", conf_les, fa[LES_W-1:0]);
    send_frame(fc, 1'b0, 1'b0);
    tick();
    check("c_les", conf_les, fc[LES_W-1:0]);
    check("c_outs", conf_outs, fc[FW-1:LES_W]);
    check("c_sel63", conf_outs[47:42], 6'd63);
    check("bc_done_count", done_cnt - d0, 1);

    // Async reset at bit 300
    start_frame();
    send_bits(fa, 300, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_les", conf_les, 0);
    check("mid_rst_outs", conf_outs, 0);
    check("mid_rst_loaded", cfg_loaded, 0);
    check("mid_rst_busy", cfg_busy, 0);
    check("mid_rst_ready", cfg_ready, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    d0 = done_cnt;
    start_frame();
    send_frame(fd, 1'b0, 1'b0);
    tick();
    check("d_les", conf_les, fd[LES_W-1:0]);
    check("d_outs", conf_outs, fd[FW-1:LES_W]);
    check("d_loaded", cfg_loaded, 1);
    check("d_done_count", done_cnt - d0, 1);

`ifdef GENETICO_CFG_PARITY_EN
    // Wrong parity rejected, then correct parity accepted
    d0 = done_cnt; e0 = err_cnt;
    start_frame();
    send_frame(fa, 1'b0, 1'b1);
    check("par_err_pulse", cfg_err, 1);
    tick();
    check("par_err_clear", cfg_err, 0);
    check("par_err_count", err_cnt - e0, 1);
    check("par_no_done", done_cnt - d0, 0);
    check("par_hold_les", conf_les, fd[LES_W-1:0]);
    check("par_idle", cfg_busy, 0);
    e0 = err_cnt;
    start_frame();
    send_frame(fa, 1'b0, 1'b0);
    check("par_ok_done", cfg_done, 1);
    tick();
    check("par_ok_les", conf_les, fa[LES_W-1:0]);
    check("par_ok_noerr", err_cnt - e0, 0);
`else
    check("no_err_ever", err_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
